// File: rtl/adder_pipe.sv
// adder_pipe: pipelined two's-complement adder/subtractor. Each stage ripples the
// carry through one SLICE-bit slice; a single global stall freezes the whole pipe.
module adder_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             ovf
);

  localparam int SLICE = WIDTH / STAGES;
  // Skew registers only feed stages 1..STAGES-1; keep one dummy entry when STAGES = 1.
  localparam int SKEW  = (STAGES > 1) ? STAGES - 1 : 1;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_q   [SKEW];
  logic [WIDTH-1:0]  a_d   [SKEW];
  logic [WIDTH-1:0]  b_q   [SKEW];
  logic [WIDTH-1:0]  b_d   [SKEW];
  logic              ovf_q, ovf_d;
  logic              stall_s;

  // Next-state of every stage: one slice of ripple carry per stage, skew/deskew passed along.
  always_comb begin
    logic [WIDTH-1:0] src_a, src_b, src_sum;
    logic             c, cm, ai, bi;
    int               kp, ks, idx;
    stall_s = valid_q[STAGES-1] & ~out_ready;
    ovf_d   = 1'b0;
    valid_d = '0;
    carry_d = '0;
    src_a   = '0;
    src_b   = '0;
    src_sum = '0;
    c       = 1'b0;
    cm      = 1'b0;
    ai      = 1'b0;
    bi      = 1'b0;
    kp      = 0;
    ks      = 0;
    idx     = 0;
    for (int j = 0; j < SKEW; j++) begin
      a_d[j] = a_q[j];
      b_d[j] = b_q[j];
    end
    for (int k = 0; k < STAGES; k++) begin
      kp = (k > 0) ? k - 1 : 0;
      ks = (k < SKEW) ? k : SKEW - 1;
      if (k == 0) begin
        src_a      = a;
        src_b      = sub ? ~b : b;
        src_sum    = '0;
        c          = c_in ^ sub;
        valid_d[k] = in_valid;
      end else begin
        src_a      = a_q[kp];
        src_b      = b_q[kp];
        src_sum    = sum_q[kp];
        c          = carry_q[kp];
        valid_d[k] = valid_q[kp];
      end
      cm = c;
      for (int i = 0; i < SLICE; i++) begin
        idx          = k * SLICE + i;
        ai           = src_a[idx];
        bi           = src_b[idx];
        cm           = c;
        src_sum[idx] = ai ^ bi ^ c;
        c            = (ai & bi) | (c & (ai ^ bi));
      end
      sum_d[k]   = src_sum;
      carry_d[k] = c;
      a_d[ks]    = (k < STAGES - 1) ? src_a : a_d[ks];
      b_d[ks]    = (k < STAGES - 1) ? src_b : b_d[ks];
      // cm is the carry into the MSB once the top slice has been rippled.
      ovf_d      = (k == STAGES - 1) ? (cm ^ c) : ovf_d;
    end
  end

  // Pipeline registers: cleared asynchronously, frozen as a whole while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
      end
      for (int j = 0; j < SKEW; j++) begin
        a_q[j] <= '0;
        b_q[j] <= '0;
      end
    end else if (!stall_s) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= sum_d[k];
      end
      for (int j = 0; j < SKEW; j++) begin
        a_q[j] <= a_d[j];
        b_q[j] <= b_d[j];
      end
    end
  end

  assign in_ready  = ~stall_s;
  assign out_valid = valid_q[STAGES-1];
  assign sum_out   = sum_q[STAGES-1];
  assign c_out     = carry_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed tests on the 8-bit/2-stage build plus a queue
// scoreboard driving random streams through five parameter configurations.
module tb_adder_pipe;

  logic        clk;
  logic        reset_n;
  logic [4:0]  iv;
  logic [4:0]  ordy;
  logic [31:0] a_s, b_s;
  logic        ci_s, sub_s;
  wire  [4:0]  ir_w, ov_w, co_w, of_w;
  wire  [7:0]  so0, so1, so2;
  wire  [31:0] so3;
  wire  [15:0] so4;

  int          checks;
  int          failures;
  int          cur;
  logic        ov_m, ir_m, co_m, of_m;
  logic [31:0] so_m;
  logic [33:0] exp_q [$];
  int          cfg_w [5] = '{8, 8, 8, 32, 16};

  adder_pipe #(.WIDTH(8), .STAGES(2)) u_d0 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(ir_w[0]),
    .a(a_s[7:0]), .b(b_s[7:0]), .c_in(ci_s), .sub(sub_s),
    .out_valid(ov_w[0]), .out_ready(ordy[0]), .sum_out(so0), .c_out(co_w[0]), .ovf(of_w[0]));
  adder_pipe #(.WIDTH(8), .STAGES(1)) u_d1 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(ir_w[1]),
    .a(a_s[7:0]), .b(b_s[7:0]), .c_in(ci_s), .sub(sub_s),
    .out_valid(ov_w[1]), .out_ready(ordy[1]), .sum_out(so1), .c_out(co_w[1]), .ovf(of_w[1]));
  adder_pipe #(.WIDTH(8), .STAGES(8)) u_d2 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(ir_w[2]),
    .a(a_s[7:0]), .b(b_s[7:0]), .c_in(ci_s), .sub(sub_s),
    .out_valid(ov_w[2]), .out_ready(ordy[2]), .sum_out(so2), .c_out(co_w[2]), .ovf(of_w[2]));
  adder_pipe #(.WIDTH(32), .STAGES(4)) u_d3 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[3]), .in_ready(ir_w[3]),
    .a(a_s), .b(b_s), .c_in(ci_s), .sub(sub_s),
    .out_valid(ov_w[3]), .out_ready(ordy[3]), .sum_out(so3), .c_out(co_w[3]), .ovf(of_w[3]));
  adder_pipe #(.WIDTH(16), .STAGES(2)) u_d4 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[4]), .in_ready(ir_w[4]),
    .a(a_s[15:0]), .b(b_s[15:0]), .c_in(ci_s), .sub(sub_s),
    .out_valid(ov_w[4]), .out_ready(ordy[4]), .sum_out(so4), .c_out(co_w[4]), .ovf(of_w[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation mux onto the instance currently under test.
  always_comb begin
    ov_m = ov_w[cur];
    ir_m = ir_w[cur];
    co_m = co_w[cur];
    of_m = of_w[cur];
    case (cur)
      0:       so_m = {24'd0, so0};
      1:       so_m = {24'd0, so1};
      2:       so_m = {24'd0, so2};
      3:       so_m = so3;
      4:       so_m = {16'd0, so4};
      default: so_m = 32'd0;
    endcase
  end

  // Reference: {ovf, c_out, sum} for a w-bit add/subtract.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic sb);
    logic [63:0] mask, aa, bb, t;
    logic [31:0] s;
    logic        c, o;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = sb ? (~{32'd0, b} & mask) : ({32'd0, b} & mask);
    t    = aa + bb + {63'd0, ci ^ sb};
    s    = t[31:0] & mask[31:0];
    c    = t[w];
    o    = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {o, c, s};
  endfunction

  task automatic test_reset();
    cur     = 0;
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_s   = $urandom;
      b_s   = $urandom;
      ci_s  = 1'($urandom_range(0, 1));
      sub_s = 1'($urandom_range(0, 1));
      iv    = 5'b00001;
      @(negedge clk);
      checks++;
      if ({ov_m, so_m, co_m, of_m, ir_m} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL reset_state: got v=%b s=%h c=%b o=%b rdy=%b, expected v=0 s=00 c=0 o=0 rdy=1",
                 ov_m, so_m, co_m, of_m, ir_m);
      end
    end
    @(posedge clk);
    #1;
    iv      = 5'b00000;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ov_m !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle: out_valid got %b expected 0", ov_m);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_cross_slice();
    cur   = 0;
    a_s   = 32'h0F;
    b_s   = 32'h01;
    ci_s  = 1'b0;
    sub_s = 1'b0;
    iv    = 5'b00001;
    @(posedge clk);
    #1;
    iv = 5'b00000;
    @(negedge clk);
    checks++;
    if (ov_m !== 1'b0) begin
      failures++;
      $display("FAIL xslice_latency: out_valid one cycle after accept got %b expected 0", ov_m);
    end
    @(negedge clk);
    checks++;
    if ({ov_m, so_m[7:0], co_m, of_m} !== {1'b1, 8'h10, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL xslice_result: got v=%b s=%h c=%b o=%b expected v=1 s=10 c=0 o=0",
               ov_m, so_m[7:0], co_m, of_m);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_carry_ovf();
    logic [7:0] ta [3] = '{8'hFF, 8'h7F, 8'h7F};
    logic [7:0] tb [3] = '{8'h01, 8'h01, 8'h00};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] es [3] = '{8'h00, 8'h80, 8'h80};
    logic       ec [3] = '{1'b1, 1'b0, 1'b0};
    logic       eo [3] = '{1'b0, 1'b1, 1'b1};
    cur = 0;
    for (int i = 0; i < 3; i++) begin
      a_s   = {24'd0, ta[i]};
      b_s   = {24'd0, tb[i]};
      ci_s  = tc[i];
      sub_s = 1'b0;
      iv    = 5'b00001;
      @(posedge clk);
      #1;
      iv = 5'b00000;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({ov_m, so_m[7:0], co_m, of_m} !== {1'b1, es[i], ec[i], eo[i]}) begin
        failures++;
        $display("FAIL carry_ovf_%0d: got v=%b s=%h c=%b o=%b expected v=1 s=%h c=%b o=%b",
                 i, ov_m, so_m[7:0], co_m, of_m, es[i], ec[i], eo[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_subtract();
    logic [7:0] ta [3] = '{8'h05, 8'h80, 8'h10};
    logic [7:0] tb [3] = '{8'h07, 8'h01, 8'h00};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] es [3] = '{8'hFE, 8'h7F, 8'h0F};
    logic       ec [3] = '{1'b0, 1'b1, 1'b1};
    logic       eo [3] = '{1'b0, 1'b1, 1'b0};
    cur = 0;
    for (int i = 0; i < 3; i++) begin
      a_s   = {24'd0, ta[i]};
      b_s   = {24'd0, tb[i]};
      ci_s  = tc[i];
      sub_s = 1'b1;
      iv    = 5'b00001;
      @(posedge clk);
      #1;
      iv = 5'b00000;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({ov_m, so_m[7:0], co_m, of_m} !== {1'b1, es[i], ec[i], eo[i]}) begin
        failures++;
        $display("FAIL subtract_%0d: got v=%b s=%h c=%b o=%b expected v=1 s=%h c=%b o=%b",
                 i, ov_m, so_m[7:0], co_m, of_m, es[i], ec[i], eo[i]);
      end
      @(posedge clk);
      #1;
    end
    sub_s = 1'b0;
  endtask

  task automatic test_backpressure();
    int          next, got;
    logic [33:0] obs, held, exp;
    cur  = 0;
    exp_q.delete();
    next = 1;
    got  = 0;
    held = '0;
    for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
      ordy[0] = !(cyc >= 2 && cyc <= 4);
      a_s     = 32'h11 * next;
      b_s     = next;
      ci_s    = 1'b0;
      sub_s   = 1'b0;
      iv[0]   = (next <= 6);
      @(negedge clk);
      obs = {of_m, co_m, so_m};
      if (cyc >= 2 && cyc <= 4) begin
        checks++;
        if (ir_m !== 1'b0 || ov_m !== 1'b1) begin
          failures++;
          $display("FAIL bp_stall_%0d: got in_ready=%b out_valid=%b expected 0 and 1", cyc, ir_m, ov_m);
        end
        if (cyc == 2) begin
          held = obs;
        end else begin
          checks++;
          if (obs !== held) begin
            failures++;
            $display("FAIL bp_hold_%0d: got %h expected %h", cyc, obs, held);
          end
        end
      end
      if (cyc >= 5 && got < 6) begin
        checks++;
        if (ov_m !== 1'b1) begin
          failures++;
          $display("FAIL bp_rate_%0d: out_valid got %b expected 1", cyc, ov_m);
        end
      end
      if (iv[0] && ir_m) begin
        exp_q.push_back(model(8, a_s, b_s, ci_s, sub_s));
        next++;
      end
      if (ov_m && ordy[0]) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL bp_result_%0d: got %h expected %h", got + 1, obs, exp);
        end
        got++;
      end
      @(posedge clk);
      #1;
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    checks++;
    if (got !== 6 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL bp_count: got %0d results (%0d pending) expected 6 (0)", got, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int          seen;
    logic [33:0] obs, exp;
    cur   = 0;
    a_s   = 32'h21;
    b_s   = 32'h12;
    ci_s  = 1'b0;
    sub_s = 1'b0;
    iv    = 5'b00001;
    @(posedge clk);
    #1;
    a_s = 32'h33;
    b_s = 32'h44;
    @(posedge clk);
    #1;
    iv = 5'b00000;
    checks++;
    if (ov_m !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: out_valid got %b expected 1", ov_m);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (ov_m !== 1'b0 || ir_m !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_async: got out_valid=%b in_ready=%b expected 0 and 1", ov_m, ir_m);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    a_s     = 32'h05;
    b_s     = 32'h0A;
    exp     = model(8, 32'h05, 32'h0A, 1'b0, 1'b0);
    iv      = 5'b00001;
    @(posedge clk);
    #1;
    iv   = 5'b00000;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      obs = {of_m, co_m, so_m};
      if (ov_m) begin
        seen++;
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL rst_mid_result: got %h expected %h", obs, exp);
        end
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (seen !== 1) begin
      failures++;
      $display("FAIL rst_mid_count: got %0d results expected 1", seen);
    end
  endtask

  task automatic test_random(input int sel, input int nops);
    int          sent, got, cyc;
    logic [33:0] obs, held, exp;
    logic        was_stall, acc;
    cur = sel;
    exp_q.delete();
    sent      = 0;
    got       = 0;
    cyc       = 0;
    was_stall = 1'b0;
    held      = '0;
    a_s       = $urandom;
    b_s       = $urandom;
    ci_s      = 1'($urandom_range(0, 1));
    sub_s     = 1'($urandom_range(0, 1));
    iv[sel]   = ($urandom_range(0, 9) < 7);
    ordy[sel] = ($urandom_range(0, 9) < 7);
    while (got < nops && cyc < nops * 20) begin
      @(negedge clk);
      obs = {of_m, co_m, so_m};
      if (was_stall) begin
        checks++;
        if (obs !== held || ov_m !== 1'b1) begin
          failures++;
          $display("FAIL rand%0d_hold: got v=%b %h expected v=1 %h", sel, ov_m, obs, held);
        end
      end
      was_stall = ov_m & ~ordy[sel];
      held      = obs;
      acc       = iv[sel] & ir_m;
      if (acc) begin
        exp_q.push_back(model(cfg_w[sel], a_s, b_s, ci_s, sub_s));
        sent++;
      end
      if (ov_m && ordy[sel]) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL rand%0d_result_%0d: got %h expected %h", sel, got, obs, exp);
        end
        got++;
      end
      @(posedge clk);
      #1;
      if (acc || !iv[sel]) begin
        a_s     = $urandom;
        b_s     = $urandom;
        ci_s    = 1'($urandom_range(0, 1));
        sub_s   = 1'($urandom_range(0, 1));
        iv[sel] = (sent < nops) && ($urandom_range(0, 9) < 7);
      end
      ordy[sel] = ($urandom_range(0, 9) < 7);
      cyc++;
    end
    iv[sel]   = 1'b0;
    ordy[sel] = 1'b1;
    checks++;
    if (got !== nops) begin
      failures++;
      $display("FAIL rand%0d_count: got %0d results in %0d cycles expected %0d", sel, got, cyc, nops);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cur      = 0;
    reset_n  = 1'b0;
    iv       = 5'b00000;
    ordy     = 5'b11111;
    a_s      = 32'd0;
    b_s      = 32'd0;
    ci_s     = 1'b0;
    sub_s    = 1'b0;
    test_reset();
    test_cross_slice();
    test_carry_ovf();
    test_subtract();
    test_backpressure();
    test_reset_mid();
    for (int s = 0; s < 5; s++) begin
      test_random(s, 1000);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
